// File: rtl/snes_color_latch.sv
// SNES button to VGA colour latch: synchronises and debounces active-low buttons,
// priority-selects the lowest pressed index and holds its palette colour on registered outputs.
module snes_color_latch #(
    parameter int NUM_BUTTONS     = 6,
    parameter int COLOR_W         = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter logic [NUM_BUTTONS*3*COLOR_W-1:0] PALETTE =
        {12'hFF0, 12'h0F0, 12'h00F, 12'h0FF, 12'hFFF, 12'h000},
    parameter logic [3*COLOR_W-1:0] RESET_COLOR = '0,
    localparam int IDX_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_BUTTONS-1:0] BTN_N,
    input  logic                   LOCK,
    output logic [COLOR_W-1:0]     RED,
    output logic [COLOR_W-1:0]     GREEN,
    output logic [COLOR_W-1:0]     BLUE,
    output logic [IDX_W-1:0]       IDX,
    output logic                   VALID,
    output logic                   CHANGED,
    output logic [NUM_BUTTONS-1:0] BTN_STABLE_N
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int CW3 = 3 * COLOR_W;

    logic [NUM_BUTTONS-1:0] s1_q, s2_q;
    logic [NUM_BUTTONS-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_d [NUM_BUTTONS];

    logic [CW3-1:0]   color_q, color_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;

    logic [NUM_BUTTONS-1:0] pressed;
    logic                   any_pressed;
    logic [IDX_W-1:0]       sel_idx;
    logic [CW3-1:0]         sel_color;

    // A level must disagree with the debounced state for DEBOUNCE_CYCLES edges in a row to flip it.
    always_comb begin
        for (int b = 0; b < NUM_BUTTONS; b++) begin
            stable_d[b] = stable_q[b];
            cnt_d[b]    = '0;
            if (s2_q[b] != stable_q[b]) begin
                if (cnt_q[b] == CNT_MAX) begin
                    stable_d[b] = s2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Descending scan so the lowest pressed index is the last (winning) assignment.
    always_comb begin
        pressed     = ~stable_q;
        any_pressed = |pressed;
        sel_idx     = '0;
        sel_color   = PALETTE[CW3-1:0];
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (pressed[i]) begin
                sel_idx   = IDX_W'(i);
                sel_color = PALETTE[i*CW3 +: CW3];
            end
        end
    end

    always_comb begin
        color_d   = color_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        if (!LOCK && any_pressed) begin
            color_d   = sel_color;
            idx_d     = sel_idx;
            valid_d   = 1'b1;
            changed_d = !valid_q || (sel_idx != idx_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q      <= '1;
            s2_q      <= '1;
            stable_q  <= '1;
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                cnt_q[b] <= '0;
            end
            color_q   <= RESET_COLOR;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= BTN_N;
            s2_q      <= s1_q;
            stable_q  <= stable_d;
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            color_q   <= color_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign RED          = color_q[CW3-1 -: COLOR_W];
    assign GREEN        = color_q[2*COLOR_W-1 -: COLOR_W];
    assign BLUE         = color_q[COLOR_W-1:0];
    assign IDX          = idx_q;
    assign VALID        = valid_q;
    assign CHANGED      = changed_q;
    assign BTN_STABLE_N = stable_q;

endmodule

// File: tb/tb_snes_color_latch.sv
// Bench for snes_color_latch: directed scenarios with fixed expectations plus
// randomized button/lock/reset traffic checked against a cycle-level reference model.
module tb_snes_color_latch;

    localparam int NB = 6;
    localparam int CW = 4;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lock = 1'b0;
    logic [NB-1:0] btn_n = '1;
    logic [CW-1:0] red, green, blue;
    logic [2:0]    idx;
    logic          valid, changed;
    logic [NB-1:0] stable_n;

    always #5 clk = ~clk;

    snes_color_latch dut (
        .CLK(clk), .RST(rst), .BTN_N(btn_n), .LOCK(lock),
        .RED(red), .GREEN(green), .BLUE(blue), .IDX(idx),
        .VALID(valid), .CHANGED(changed), .BTN_STABLE_N(stable_n)
    );

    int checks = 0;
    int errors = 0;

    // Palette by button name: Select, Start, A, B, X, Y.
    logic [11:0] pal [NB] = '{12'h000, 12'hFFF, 12'h0FF, 12'h00F, 12'h0F0, 12'hFF0};

    // Reference model: a button's debounced level follows its synchronised level once
    // that level has disagreed for D consecutive edges; the colour follows the lowest pressed button.
    logic [NB-1:0] m_s1 = '1, m_s2 = '1, m_stable = '1;
    int            m_run [NB];
    logic [11:0]   m_rgb = '0;
    logic [2:0]    m_idx = '0;
    logic          m_valid = 1'b0, m_changed = 1'b0;
    int            m_sel;
    logic [14:0]   exp_q [$];
    logic [14:0]   obs_q [$];
    int            dut_chg = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '1; m_s2 = '1; m_stable = '1;
            for (int b = 0; b < NB; b++) m_run[b] = 0;
            m_rgb = '0; m_idx = '0; m_valid = 1'b0; m_changed = 1'b0;
        end else begin
            m_sel = -1;
            for (int b = NB - 1; b >= 0; b--) if (!m_stable[b]) m_sel = b;
            if (!lock && m_sel >= 0) begin
                m_changed = !m_valid || (m_sel != int'(m_idx));
                m_rgb = pal[m_sel];
                m_idx = 3'(m_sel);
                m_valid = 1'b1;
                if (m_changed) exp_q.push_back({m_idx, m_rgb});
            end else begin
                m_changed = 1'b0;
            end
            for (int b = 0; b < NB; b++) begin
                if (m_s2[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] == D) begin
                        m_stable[b] = m_s2[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_n;
        end
    end

    // Record every CHANGED pulse the DUT emits, sampled between edges.
    always begin
        @(posedge clk);
        #2;
        if (changed === 1'b1) begin
            obs_q.push_back({idx, red, green, blue});
            dut_chg++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int c0;
        rst = 1'b1; btn_n = '1; lock = 1'b0;
        step(2);
        rst = 1'b0;
        c0 = dut_chg;
        step(100);
        checks++;
        if ({red, green, blue} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", {red, green, blue}); end
        checks++;
        if (valid !== 1'b0 || idx !== 3'd0) begin errors++; $display("FAIL reset_valid_idx got %b/%0d want 0/0", valid, idx); end
        checks++;
        if (stable_n !== 6'h3F) begin errors++; $display("FAIL reset_stable got %h want 3f", stable_n); end
        checks++;
        if (dut_chg !== c0) begin errors++; $display("FAIL reset_changed got %0d pulses want 0", dut_chg - c0); end
    endtask

    task automatic test_single_press();
        int c0;
        btn_n[2] = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (changed !== (k == 18)) begin errors++; $display("FAIL press_latency edge %0d changed got %b want %b", k, changed, k == 18); end
            checks++;
            if (stable_n[2] !== !(k >= 17)) begin errors++; $display("FAIL press_stable edge %0d got %b want %b", k, stable_n[2], !(k >= 17)); end
        end
        checks++;
        if ({red, green, blue, idx, valid} !== {12'h0FF, 3'd2, 1'b1}) begin
            errors++; $display("FAIL press_color got %h idx %0d valid %b want 0ff idx 2 valid 1", {red, green, blue}, idx, valid);
        end
        btn_n = '1;
        c0 = dut_chg;
        step(40);
        checks++;
        if ({red, green, blue, idx} !== {12'h0FF, 3'd2} || dut_chg !== c0) begin
            errors++; $display("FAIL release_hold got %h idx %0d pulses %0d want 0ff idx 2 pulses 0", {red, green, blue}, idx, dut_chg - c0);
        end
    endtask

    task automatic test_glitch();
        int c0;
        c0 = dut_chg;
        for (int r = 0; r < 3; r++) begin
            btn_n[3] = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                checks++;
                if (stable_n[3] !== 1'b1) begin errors++; $display("FAIL glitch_stable rep %0d cyc %0d got 0 want 1", r, k); end
            end
            btn_n[3] = 1'b1;
            step(2);
        end
        step(4);
        checks++;
        if ({red, green, blue, idx} !== {12'h0FF, 3'd2} || dut_chg !== c0) begin
            errors++; $display("FAIL glitch_color got %h idx %0d pulses %0d want 0ff idx 2 pulses 0", {red, green, blue}, idx, dut_chg - c0);
        end
        btn_n[3] = 1'b0;
        step(20);
        checks++;
        if ({red, green, blue, idx} !== {12'h00F, 3'd3}) begin
            errors++; $display("FAIL held_b got %h idx %0d want 00f idx 3", {red, green, blue}, idx);
        end
    endtask

    task automatic test_priority();
        int c0;
        btn_n = '1;
        step(20);
        c0 = dut_chg;
        btn_n[5] = 1'b0;
        step(20);
        checks++;
        if ({red, green, blue, idx} !== {12'hFF0, 3'd5}) begin errors++; $display("FAIL prio_y got %h idx %0d want ff0 idx 5", {red, green, blue}, idx); end
        btn_n[4] = 1'b0;
        step(20);
        checks++;
        if ({red, green, blue, idx} !== {12'h0F0, 3'd4}) begin errors++; $display("FAIL prio_xy got %h idx %0d want 0f0 idx 4", {red, green, blue}, idx); end
        btn_n[4] = 1'b1;
        step(20);
        checks++;
        if ({red, green, blue, idx} !== {12'hFF0, 3'd5}) begin errors++; $display("FAIL prio_release_x got %h idx %0d want ff0 idx 5", {red, green, blue}, idx); end
        checks++;
        if (dut_chg - c0 !== 3) begin errors++; $display("FAIL prio_pulses got %0d want 3", dut_chg - c0); end
        btn_n = '1;
        step(20);
        c0 = dut_chg;
        btn_n[5] = 1'b0;
        step(20);
        checks++;
        if (dut_chg !== c0 || idx !== 3'd5) begin errors++; $display("FAIL repress_y pulses %0d idx %0d want 0 idx 5", dut_chg - c0, idx); end
        btn_n = '1;
        step(20);
    endtask

    task automatic test_lock();
        int c0;
        c0 = dut_chg;
        lock = 1'b1;
        btn_n[1] = 1'b0;
        step(25);
        checks++;
        if (stable_n[1] !== 1'b0) begin errors++; $display("FAIL lock_stable got 1 want 0"); end
        checks++;
        if ({red, green, blue, idx} !== {12'hFF0, 3'd5} || dut_chg !== c0) begin
            errors++; $display("FAIL lock_hold got %h idx %0d pulses %0d want ff0 idx 5 pulses 0", {red, green, blue}, idx, dut_chg - c0);
        end
        lock = 1'b0;
        @(negedge clk);
        checks++;
        if ({red, green, blue, idx, changed} !== {12'hFFF, 3'd1, 1'b1}) begin
            errors++; $display("FAIL unlock got %h idx %0d changed %b want fff idx 1 changed 1", {red, green, blue}, idx, changed);
        end
        btn_n = '1;
        step(20);
    endtask

    task automatic test_reset_mid();
        btn_n[0] = 1'b0;
        step(10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({red, green, blue, idx, valid, changed, stable_n} !== {12'h000, 3'd0, 1'b0, 1'b0, 6'h3F}) begin
            errors++; $display("FAIL rst_mid got %h idx %0d v %b c %b st %h want 000 0 0 0 3f", {red, green, blue}, idx, valid, changed, stable_n);
        end
        for (int k = 0; k <= 18; k++) begin
            @(negedge clk);
            checks++;
            if (valid !== (k == 18) || changed !== (k == 18)) begin
                errors++; $display("FAIL rst_relatch edge %0d valid %b changed %b want %b", k, valid, changed, k == 18);
            end
        end
        checks++;
        if ({red, green, blue, idx} !== {12'h000, 3'd0}) begin errors++; $display("FAIL select_color got %h idx %0d want 000 idx 0", {red, green, blue}, idx); end
        btn_n[0] = 1'b1;
        btn_n[4] = 1'b0;
        step(25);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        btn_n = '1;
        checks++;
        if ({red, green, blue, idx, valid, stable_n} !== {12'h000, 3'd0, 1'b0, 6'h3F}) begin
            errors++; $display("FAIL rst_latched got %h idx %0d v %b st %h want 000 0 0 3f", {red, green, blue}, idx, valid, stable_n);
        end
        step(5);
    endtask

    task automatic test_random();
        int hold;
        for (int seg = 0; seg < 60; seg++) begin
            btn_n = NB'($urandom);
            lock  = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 19) == 0);
            hold  = $urandom_range(1, 40);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                rst = 1'b0;
                checks++;
                if ({red, green, blue, idx, valid, changed, stable_n} !== {m_rgb, m_idx, m_valid, m_changed, m_stable}) begin
                    errors++;
                    $display("FAIL random seg %0d got rgb %h idx %0d v %b c %b st %h want rgb %h idx %0d v %b c %b st %h",
                             seg, {red, green, blue}, idx, valid, changed, stable_n, m_rgb, m_idx, m_valid, m_changed, m_stable);
                end
            end
        end
        btn_n = '1; lock = 1'b0;
        step(25);
    endtask

    task automatic test_change_log();
        logic [14:0] e, o;
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL change_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL change_event got idx %0d rgb %h want idx %0d rgb %h", o[14:12], o[11:0], e[14:12], e[11:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_priority();
        test_lock();
        test_reset_mid();
        test_random();
        test_change_log();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snes_color_latch.md
Name: snes_color_latch

Overview:
- Parametrised, registered successor to the combinational SNES-button-to-VGA colour decoder.
- Takes NUM_BUTTONS raw active-low controller buttons, synchronises and debounces each one, and priority-selects the lowest-index pressed button.
- Latches that button's palette colour onto registered RED/GREEN/BLUE outputs.
- Adds a lock input, a valid flag and a change strobe. Sits between the SNES controller pins and the VGA pixel-colour path.

Parameters:
- NUM_BUTTONS, 6: number of button inputs (1..16).
- COLOR_W, 4: bits per colour channel.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must differ from its debounced state before that state flips (>=1).
- PALETTE, {Y:F,F,0; X:0,F,0; B:0,0,F; A:0,F,F; Start:F,F,F; Select:0,0,0}: packed NUM_BUTTONS*3*COLOR_W.
  - Entry i = {R,G,B}, entry 0 in the LSBs.
  - Default index order is 0 Select, 1 Start, 2 A, 3 B, 4 X, 5 Y.
- RESET_COLOR, 0: packed 3*COLOR_W {R,G,B} driven after reset.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- BTN_N  in  NUM_BUTTONS  raw buttons, active-low, asynchronous to CLK.
- LOCK  in  1  high: hold the current colour and ignore presses.
- RED  out  COLOR_W  latched red.
- GREEN  out  COLOR_W  latched green.
- BLUE  out  COLOR_W  latched blue.
- IDX  out  $clog2(NUM_BUTTONS) (min 1)  index of the latched entry.
- VALID  out  1  high once any entry has been latched since reset.
- CHANGED  out  1  one-cycle pulse when IDX/colour changes.
- BTN_STABLE_N  out  NUM_BUTTONS  debounced button levels, active-low.

Behaviour:
- Reset values (RST high at a CLK edge):
  - Sync flops and BTN_STABLE_N: all 1s. Debounce counters: 0.
  - RED/GREEN/BLUE: RESET_COLOR fields. IDX 0, VALID 0, CHANGED 0.
  - RST wins over every other event, including mid-debounce and LOCK.
- Synchroniser: two flops per button (s1, s2). s2 reflects BTN_N after 2 edges.
- Debounce, per button, independently:
  - If s2 == stable, counter resets to 0.
  - If s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
  - Otherwise the counter increments.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count. Both press and release are debounced.
- Selection: pressed set P = ~BTN_STABLE_N; sel = lowest set index in P.
- Latch update, in a cycle where LOCK == 0 and P != 0:
  - Colour regs <= PALETTE[sel], IDX <= sel, VALID <= 1.
  - CHANGED <= 1 if VALID was 0 or sel != IDX; else CHANGED <= 0.
- Hold: if P == 0 or LOCK == 1, all latched outputs hold and CHANGED <= 0. Releasing all buttons never clears the colour.
- Latency: a clean raw press applied before edge 0 gives BTN_STABLE_N low after edge 1+D and RED/GREEN/BLUE/CHANGED after edge 2+D, where D = DEBOUNCE_CYCLES (18 edges at default).
- Simultaneous presses: the lowest index wins regardless of press order. If the lower button is released while the higher is still held, the output switches to the higher button's colour (CHANGED pulses).
- LOCK deasserting while a button is held: update on the next edge.
- CHANGED is never high for two consecutive cycles unless sel actually differs on each.
- Width: IDX is zero-padded. PALETTE slicing is static, with no arithmetic on colour values.

Test Plan:
- Reset, then no buttons for 100 cycles -> RED/GREEN/BLUE=0,0,0, VALID=0, CHANGED never high, BTN_STABLE_N=6'h3F.
- Hold BTN_N[2] (A) low from cycle 0, defaults -> RED=0, GREEN=F, BLUE=F, IDX=2, VALID=1, CHANGED high exactly one cycle at edge 18; release -> colour holds, no CHANGED.
- Pulse BTN_N[3] low for 10 cycles, three times with 2-cycle gaps -> BTN_STABLE_N[3] stays 1, colour unchanged; then hold 16+ cycles -> BLUE=F, RED=GREEN=0, IDX=3.
- Hold Y (5) and then X (4), both debounced -> IDX=4 (0,F,0); release X -> IDX=5 (F,F,0), second CHANGED pulse; press Y again after a full release -> no CHANGED.
- LOCK=1, press Start -> outputs hold, no CHANGED, BTN_STABLE_N[1]=0; drop LOCK with Start held -> next edge F,F,F, IDX=1, CHANGED=1.
- Assert RST mid-debounce (counter 8) and also after a latched colour -> next edge all reset values; a press continuing after RST needs the full 2+D edges again.
